// File: rtl/decode_stage.sv
// decode_stage: instruction decode stage of the Jump/Add/Li processor.
// It decodes one 8-bit instruction per cycle and reads a 4x8 register file.
// It registers the two adder operands and writes the adder result back on the
// following edge, forwarding that result to dependent instructions. It also
// resolves jumps and squashes the single instruction in the jump shadow.
//
// Ports:
//   clk          system clock, rising-edge active
//   reset        asynchronous active-low reset
//   instr_valid  instr carries an instruction this cycle
//   instr        instruction word: ADD 00 rd rs rt | LI 01 rd imm | JMP 10 tgt | NOP 11
//   alu_out      sum from the execute stage, combinational from alu_input_a/b
//   alu_input_a  registered adder operand A
//   alu_input_b  registered adder operand B
//   ex_valid     registered: the operands hold a live ADD/LI that must be written back
//   ex_rd        registered destination register of the live operation
//   jump_taken   registered one-cycle pulse that redirects fetch
//   jump_target  registered jump destination, meaningful while jump_taken=1
//   dbg_sel      debug register select
//   dbg_data     raw register-file read of dbg_sel (no forwarding)
module decode_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  input  logic [7:0] alu_out,
  output logic [7:0] alu_input_a,
  output logic [7:0] alu_input_b,
  output logic       ex_valid,
  output logic [1:0] ex_rd,
  output logic       jump_taken,
  output logic [7:0] jump_target,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LI  = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;

  logic [7:0] regfile_r [4];
  logic [7:0] alu_a_r;
  logic [7:0] alu_b_r;
  logic       ex_valid_r;
  logic [1:0] ex_rd_r;
  logic       jump_taken_r;
  logic [7:0] jump_target_r;

  logic       accept_s;
  logic [7:0] nxt_a_s;
  logic [7:0] nxt_b_s;
  logic       nxt_ev_s;
  logic [1:0] nxt_rd_s;
  logic       nxt_jt_s;
  logic [7:0] nxt_tgt_s;

  // The in-flight result is written on the same edge that reads it, so a
  // matching register must take alu_out instead of the stale file entry.
  function automatic logic [7:0] opnd(
    input logic [1:0] r,
    input logic       ev,
    input logic [1:0] rd,
    input logic [7:0] fwd,
    input logic [7:0] file_val
  );
    logic [7:0] v;
    if (ev && (rd == r)) begin
      v = fwd;
    end else begin
      v = file_val;
    end
    return v;
  endfunction

  // The instruction presented while jump_taken is high is the jump shadow.
  assign accept_s = instr_valid & ~jump_taken_r;

  // Decode the accepted instruction into next-state values for the ex registers.
  always_comb begin
    nxt_a_s   = alu_a_r;
    nxt_b_s   = alu_b_r;
    nxt_rd_s  = ex_rd_r;
    nxt_ev_s  = 1'b0;
    nxt_jt_s  = 1'b0;
    nxt_tgt_s = jump_target_r;
    if (accept_s) begin
      case (instr[7:6])
        OP_ADD: begin
          nxt_a_s  = opnd(instr[3:2], ex_valid_r, ex_rd_r, alu_out, regfile_r[instr[3:2]]);
          nxt_b_s  = opnd(instr[1:0], ex_valid_r, ex_rd_r, alu_out, regfile_r[instr[1:0]]);
          nxt_rd_s = instr[5:4];
          nxt_ev_s = 1'b1;
        end
        OP_LI: begin
          // LI goes through the adder as 0 + imm so writeback has a single path.
          nxt_a_s  = 8'd0;
          nxt_b_s  = {4'd0, instr[3:0]};
          nxt_rd_s = instr[5:4];
          nxt_ev_s = 1'b1;
        end
        OP_JMP: begin
          nxt_jt_s  = 1'b1;
          nxt_tgt_s = {2'b00, instr[5:0]};
        end
        default: begin
          nxt_ev_s = 1'b0;
        end
      endcase
    end else begin
      nxt_ev_s = 1'b0;
    end
  end

  // Pipeline registers: ex operands, destination, and the jump pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a_r       <= 8'd0;
      alu_b_r       <= 8'd0;
      ex_valid_r    <= 1'b0;
      ex_rd_r       <= 2'd0;
      jump_taken_r  <= 1'b0;
      jump_target_r <= 8'd0;
    end else begin
      alu_a_r       <= nxt_a_s;
      alu_b_r       <= nxt_b_s;
      ex_valid_r    <= nxt_ev_s;
      ex_rd_r       <= nxt_rd_s;
      jump_taken_r  <= nxt_jt_s;
      jump_target_r <= nxt_tgt_s;
    end
  end

  // Register file: written back from the execute stage one edge after issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        regfile_r[i] <= 8'd0;
      end
    end else if (ex_valid_r) begin
      regfile_r[ex_rd_r] <= alu_out;
    end
  end

  assign alu_input_a = alu_a_r;
  assign alu_input_b = alu_b_r;
  assign ex_valid    = ex_valid_r;
  assign ex_rd       = ex_rd_r;
  assign jump_taken  = jump_taken_r;
  assign jump_target = jump_target_r;
  assign dbg_data    = regfile_r[dbg_sel];

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: program-order reference model, a
// per-cycle compare process, directed scenarios with literal expectations,
// then randomized instruction streams.
module tb_decode_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'd0;
  logic [7:0] alu_out;
  logic [7:0] alu_input_a, alu_input_b, jump_target, dbg_data;
  logic       ex_valid, jump_taken;
  logic [1:0] ex_rd, dbg_sel;
  logic [1:0] rnd_sel = 2'd0;
  logic [1:0] lit_sel = 2'd0;
  logic       lit_mode = 1'b0;
  logic       chk_en = 1'b0;

  int tests = 0;
  int fails = 0;

  // Model state: arch = program-order register values, comm = register file
  // contents (lag by the pending writeback).
  int         arch [4];
  int         comm [4];
  bit         pend_v;
  int         pend_rd, pend_val;
  logic       m_ev, m_jt;
  logic [1:0] m_rd;
  logic [7:0] m_a, m_b, m_tgt;

  assign alu_out = alu_input_a + alu_input_b;
  assign dbg_sel = lit_mode ? lit_sel : rnd_sel;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .alu_out(alu_out), .alu_input_a(alu_input_a), .alu_input_b(alu_input_b),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .jump_taken(jump_taken),
    .jump_target(jump_target), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sequential semantics of the instruction set.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin arch[i] = 0; comm[i] = 0; end
      pend_v = 0; m_ev = 0; m_jt = 0; m_rd = 0; m_a = 0; m_b = 0; m_tgt = 0;
    end else begin
      bit acc;
      if (pend_v) comm[pend_rd] = pend_val;
      acc = instr_valid && !m_jt;
      pend_v = 0; m_ev = 0; m_jt = 0;
      if (acc) begin
        int rd;
        rd = instr[5:4];
        if (instr[7:6] == 2'd0 || instr[7:6] == 2'd1) begin
          if (instr[7:6] == 2'd0) begin
            m_a = arch[instr[3:2]];
            m_b = arch[instr[1:0]];
          end else begin
            m_a = 0;
            m_b = instr[3:0];
          end
          arch[rd] = (int'(m_a) + int'(m_b)) % 256;
          m_rd = rd; m_ev = 1;
          pend_v = 1; pend_rd = rd; pend_val = arch[rd];
        end else if (instr[7:6] == 2'd2) begin
          m_jt = 1; m_tgt = instr[5:0];
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      rnd_sel = 2'($urandom_range(0, 3));
      #1;
      chk("ex_valid", ex_valid, m_ev);
      chk("jump_taken", jump_taken, m_jt);
      chk("alu_input_a", alu_input_a, m_a);
      chk("alu_input_b", alu_input_b, m_b);
      chk("ex_rd", ex_rd, m_rd);
      if (m_jt || !reset) chk("jump_target", jump_target, m_tgt);
      chk("dbg_data", dbg_data, comm[dbg_sel]);
    end
  end

  // Present one instruction for one edge; returns 2 time units after the next negedge.
  task automatic step(input logic v, input logic [7:0] ins);
    instr_valid = v;
    instr = ins;
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic dbg_lit(input int r, input int exp);
    lit_mode = 1'b1;
    lit_sel = 2'(r);
    #1;
    chk($sformatf("dbg_r%0d", r), dbg_data, exp);
    chk($sformatf("model_r%0d", r), comm[r], exp);
    lit_mode = 1'b0;
  endtask

  int wrap_exp [5] = '{30, 60, 120, 240, 224};

  initial begin
    chk_en = 1'b1;
    // Reset held with clock running and random instructions.
    for (int i = 0; i < 4; i++) begin
      instr_valid = 1'b1;
      instr = 8'($urandom);
      @(negedge clk); #2;
    end
    for (int r = 0; r < 4; r++) dbg_lit(r, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_jump_taken", jump_taken, 0);
    chk("rst_jump_target", jump_target, 0);
    reset = 1'b1;
    step(1'b0, 8'h00);

    // Forwarding chain: LI r1,5; LI r2,3; ADD r3,r1,r2.
    step(1'b1, 8'h55);
    step(1'b1, 8'h63);
    step(1'b1, 8'h36);
    chk("fwd_a", alu_input_a, 5);
    chk("fwd_b", alu_input_b, 3);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    dbg_lit(1, 5); dbg_lit(2, 3); dbg_lit(3, 8);

    // Wrap-around: LI r1,15 then ADD r1,r1,r1 five times.
    step(1'b1, 8'h5F);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'h15);
      chk("wrap_sum", alu_out, wrap_exp[k]);
    end
    step(1'b0, 8'h00);
    dbg_lit(1, 224);

    // Jump and shadow: JMP 0x2A; LI r0,7 (squashed); LI r1,9.
    step(1'b1, 8'hAA);
    chk("jmp_taken", jump_taken, 1);
    chk("jmp_target", jump_target, 8'h2A);
    step(1'b1, 8'h47);
    chk("shadow_jt", jump_taken, 0);
    chk("shadow_ev", ex_valid, 0);
    step(1'b1, 8'h59);
    step(1'b0, 8'h00);
    dbg_lit(0, 0); dbg_lit(1, 9);
    step(1'b1, 8'hAA);
    step(1'b1, 8'h81);
    chk("jmpjmp_pulse", jump_taken, 0);

    // Bubbles and NOPs after LI r2,4.
    step(1'b1, 8'h64);
    for (int k = 0; k < 4; k++) begin
      step(k[0], 8'hC0);
      chk("bub_ev", ex_valid, 0);
      chk("bub_a", alu_input_a, 0);
      chk("bub_b", alu_input_b, 4);
    end
    dbg_lit(2, 4);

    // Reset mid-operation while ADD r3 = 8 is pending.
    step(1'b1, 8'h55);
    step(1'b1, 8'h63);
    step(1'b1, 8'h36);
    chk("pre_rst_ev", ex_valid, 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_ev", ex_valid, 0);
    chk("rst_mid_a", alu_input_a, 0);
    dbg_lit(1, 0);
    @(posedge clk); @(negedge clk); #2;
    reset = 1'b1;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    dbg_lit(3, 0);

    // Randomized stream.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
